// File: rtl/phase_pkg.sv
// Shared types and constants for the instruction phase sequencer.
// State encoding and the one-hot phase vector layout.
package phase_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam int PH_F     = 0;
    localparam int PH_D     = 1;
    localparam int PH_E     = 2;
    localparam int PH_M     = 3;
    localparam int PH_W     = 4;
    localparam int PH_W_NUM = 5;

    function automatic logic [PH_W_NUM-1:0] phase_onehot(input state_t s);
        logic [PH_W_NUM-1:0] r;
        r = '0;
        case (s)
            FETCH:   r[PH_F] = 1'b1;
            DECODE:  r[PH_D] = 1'b1;
            EXEC:    r[PH_E] = 1'b1;
            MEM:     r[PH_M] = 1'b1;
            WB:      r[PH_W] = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == FETCH) || (s == DECODE) || (s == EXEC) || (s == MEM) || (s == WB);
    endfunction

endpackage

// File: rtl/handshake_timer.sv
// Wait counter shared by the FETCH and MEM handshakes.
// expired flags the last permitted wait cycle; TIMEOUT of 0 disables it.
module handshake_timer #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase controller: FETCH, DECODE, EXEC, optional MEM, WB.
// Optional feature macro: SINGLE_STEP_EN (adds the step input, halts after every instruction).
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt_req,
    input  logic                fetch_ready,
    input  logic                mem_op,
    input  logic                mem_ready,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [PH_W_NUM-1:0] phase,
    output logic                fetch_req,
    output logic                mem_req,
    output logic                wb_en,
    output logic                busy,
    output logic                halted,
    output logic                err,
    output logic [CNT_W-1:0]    instr_count
);

    state_t state;
    state_t nxt;
    logic   halt_pending;
    logic   waiting;
    logic   to_expired;
    logic   resume;

`ifdef SINGLE_STEP_EN
    assign resume = step;
`else
    assign resume = start;
`endif

    handshake_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (nxt != state),
        .en      (waiting),
        .expired (to_expired)
    );

    // Ready is tested before the timeout so a handshake landing on the limit still completes.
    always_comb begin
        nxt     = state;
        waiting = 1'b0;
        case (state)
            IDLE:   if (start) nxt = FETCH;
            FETCH: begin
                if (fetch_ready)     nxt = DECODE;
                else if (to_expired) nxt = ERR;
                else                 waiting = 1'b1;
            end
            DECODE: nxt = EXEC;
            EXEC:   nxt = mem_op ? MEM : WB;
            MEM: begin
                if (mem_ready)       nxt = WB;
                else if (to_expired) nxt = ERR;
                else                 waiting = 1'b1;
            end
`ifdef SINGLE_STEP_EN
            WB:     nxt = HALT;
`else
            WB:     nxt = (halt_pending || halt_req) ? HALT : FETCH;
`endif
            HALT:   if (resume) nxt = FETCH;
            ERR:    nxt = ERR;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= '0;
            fetch_req    <= 1'b0;
            mem_req      <= 1'b0;
            wb_en        <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            err          <= 1'b0;
            halt_pending <= 1'b0;
            instr_count  <= '0;
        end else begin
            state     <= nxt;
            phase     <= phase_onehot(nxt);
            fetch_req <= (nxt == FETCH);
            mem_req   <= (nxt == MEM);
            wb_en     <= (nxt == WB);
            busy      <= is_busy(nxt);
            halted    <= (nxt == HALT);
            err       <= (nxt == ERR);

            if (state == WB) begin
                instr_count <= instr_count + CNT_W'(1);
            end

            if (nxt == HALT && state != HALT) begin
                halt_pending <= 1'b0;
            end else if (halt_req && (is_busy(state) || (state == HALT && resume))) begin
                halt_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer (TIMEOUT overridden to 4).
// Builds with or without SINGLE_STEP_EN; the halt/step scenarios follow the macro.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        fetch_ready;
    logic        mem_op;
    logic        mem_ready;
    logic        step;
    logic [4:0]  phase;
    logic        fetch_req;
    logic        mem_req;
    logic        wb_en;
    logic        busy;
    logic        halted;
    logic        err;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [4:0] P_F = 5'b00001;
    localparam logic [4:0] P_D = 5'b00010;
    localparam logic [4:0] P_E = 5'b00100;
    localparam logic [4:0] P_M = 5'b01000;
    localparam logic [4:0] P_W = 5'b10000;

    always #5 clk = ~clk;

    phase_sequencer #(
        .CNT_W   (32),
        .TO_W    (8),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .fetch_ready (fetch_ready),
        .mem_op      (mem_op),
        .mem_ready   (mem_ready),
`ifdef SINGLE_STEP_EN
        .step        (step),
`endif
        .phase       (phase),
        .fetch_req   (fetch_req),
        .mem_req     (mem_req),
        .wb_en       (wb_en),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .instr_count (instr_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle; outputs are then stable and inputs may be changed.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; fetch_ready = 1'b0;
        mem_op = 1'b0; mem_ready = 1'b0; step = 1'b0;
        nxt();
        nxt();
        check("rst_phase", phase, 0);
        check("rst_fetch_req", fetch_req, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_count", instr_count, 0);
        rst_n = 1'b1;
        nxt();
        check("idle_hold", phase, 0);

`ifndef SINGLE_STEP_EN
        // Back-to-back register-only instructions
        fetch_ready = 1'b1;
        start = 1'b1;
        nxt();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            case (i % 4)
                0: check("seq_phase_F", phase, P_F);
                1: check("seq_phase_D", phase, P_D);
                2: check("seq_phase_E", phase, P_E);
                default: check("seq_phase_W", phase, P_W);
            endcase
            if (i == 3) check("seq_wb_en", wb_en, 1);
            nxt();
        end
        check("seq_count3", instr_count, 3);
        check("seq_refetch", phase, P_F);

        // Memory phase with ready on the fourth MEM cycle (also the timeout limit)
        mem_op = 1'b1;
        nxt();
        check("mem_dec", phase, P_D);
        nxt();
        check("mem_exec", phase, P_E);
        nxt();
        for (int k = 0; k < 4; k++) begin
            check("mem_req_hold", mem_req, 1);
            check("mem_phase_hold", phase, P_M);
            if (k == 3) mem_ready = 1'b1;
            nxt();
        end
        check("mem_wb_en", wb_en, 1);
        check("mem_wb_phase", phase, P_W);
        check("mem_no_err", err, 0);
        mem_op = 1'b0;
        mem_ready = 1'b0;
        nxt();
        check("mem_wb_once", wb_en, 0);
        check("mem_count4", instr_count, 4);

        // Halt requested mid-instruction completes WB before halting
        nxt();
        check("halt_dec", phase, P_D);
        halt_req = 1'b1;
        nxt();
        halt_req = 1'b0;
        check("halt_exec", phase, P_E);
        nxt();
        check("halt_wb", wb_en, 1);
        nxt();
        check("halted", halted, 1);
        check("halt_phase", phase, 0);
        check("halt_busy", busy, 0);
        check("halt_count5", instr_count, 5);
        nxt();
        check("halt_stay", halted, 1);
        start = 1'b1;
        halt_req = 1'b1;
        nxt();
        start = 1'b0;
        halt_req = 1'b0;
        check("resume_fetch", phase, P_F);
        check("resume_unhalted", halted, 0);
        nxt();
        nxt();
        nxt();
        check("repend_wb", wb_en, 1);
        nxt();
        check("repend_halted", halted, 1);
        check("repend_count6", instr_count, 6);
        start = 1'b1;
        nxt();
        start = 1'b0;
        check("resume2_fetch", phase, P_F);
`else
        // Single-step: each step runs exactly one instruction then halts
        fetch_ready = 1'b1;
        start = 1'b1;
        nxt();
        start = 1'b0;
        check("ss_fetch", phase, P_F);
        nxt();
        nxt();
        nxt();
        check("ss_wb", wb_en, 1);
        nxt();
        check("ss_halted0", halted, 1);
        check("ss_count1", instr_count, 1);
        for (int s = 1; s <= 3; s++) begin
            if (s == 1) begin
                start = 1'b1;
                nxt();
                start = 1'b0;
                check("ss_start_ignored", halted, 1);
            end
            repeat (10) nxt();
            check("ss_between", halted, 1);
            step = 1'b1;
            nxt();
            step = 1'b0;
            check("ss_step_fetch", phase, P_F);
            nxt();
            nxt();
            nxt();
            nxt();
            check("ss_halt_after", halted, 1);
            check("ss_count", instr_count, 64'(s + 1));
        end
        check("ss_count4", instr_count, 4);
`endif

        // Reset in the middle of a MEM wait
        do_reset();
        fetch_ready = 1'b1;
        mem_op = 1'b1;
        mem_ready = 1'b0;
        start = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        nxt();
        nxt();
        check("rm_mem_req", mem_req, 1);
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        mem_op = 1'b0;
        check("rm_phase", phase, 0);
        check("rm_mem_req0", mem_req, 0);
        check("rm_busy", busy, 0);
        check("rm_count", instr_count, 0);
        nxt();
        check("rm_idle", phase, 0);

        // Fetch timeout traps into ERR
        fetch_ready = 1'b0;
        start = 1'b1;
        nxt();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("to_fetch_wait", phase, P_F);
            nxt();
        end
        check("to_err", err, 1);
        check("to_phase0", phase, 0);
        check("to_fetch_req0", fetch_req, 0);
        check("to_busy0", busy, 0);
        start = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        check("to_err_sticky", err, 1);
        check("to_start_ignored", phase, 0);
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        check("to_err_cleared", err, 0);
        nxt();
        check("to_idle", phase, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
